or1200_checker_alarm: RTL and testbench

Downstream response stage for the OR1200 CPU-level privilege checker. Consumes the checker's `sr_ok`, `pipeline_ok` and `mmus_ok` flags and its parity-coded `secure_supv` word. It filters single-cycle transients, detects illegal user-to-supervisor escalation, latches sticky fault causes, and runs a request/acknowledge handshake with the recovery logic (trap or rollback controller). All outputs are registered.

---
 rtl/or1200_checker_alarm.sv | 118 +++++++++++
 tb/tb_or1200_checker_alarm.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/or1200_checker_alarm.sv
// or1200_checker_alarm: filters checker faults, latches sticky causes and runs the recovery handshake
module or1200_checker_alarm #(
  parameter int unsigned GRACE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sr_ok,
  input  logic       pipeline_ok,
  input  logic       mmus_ok,
  input  logic [2:0] secure_supv,
  input  logic       except_started,
  input  logic       recover_ack,
  input  logic       clear,
  output logic       alarm,
  output logic       recover_req,
  output logic [3:0] cause,
  output logic       supv_dec,
  output logic [7:0] viol_count,
  output logic [1:0] state
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    ALARM   = 2'd2,
    RECOVER = 2'd3
  } state_t;
  localparam logic [3:0] GRACE = 4'(GRACE_CYCLES);
  state_t     state_q, state_d;
  logic [3:0] grace_cnt_q, grace_cnt_d;
  logic [3:0] pend_q, pend_d;
  logic [3:0] cause_q, cause_d;
  logic [7:0] viol_count_q, viol_count_d;
  logic       supv_dec_q, supv_dec_d;
  logic       exc_prev_q, exc_prev_d;
  logic       alarm_q, alarm_d;
  logic       recover_req_q, recover_req_d;
  logic       supv_now, esc, any, from_idle;
  logic [3:0] f;
  // fault qualification, incident FSM and counters; a clear in RECOVER re-evaluates the cycle as IDLE
  always_comb begin
    supv_now = ~^secure_supv;
    esc = enable & supv_now & ~supv_dec_q & ~except_started & ~exc_prev_q;
    f = enable ? {esc, ~mmus_ok, ~pipeline_ok, ~sr_ok} : 4'b0;
    any = |f;
    from_idle = (state_q == IDLE) || (state_q == RECOVER && clear);
    state_d = state_q;
    grace_cnt_d = grace_cnt_q;
    pend_d = pend_q;
    cause_d = cause_q;
    if (from_idle) begin
      state_d = IDLE;
      grace_cnt_d = 4'd0;
      pend_d = 4'd0;
      cause_d = 4'd0;
      if (f[3] || (any && GRACE == 4'd1)) begin
        state_d = ALARM;
        cause_d = f;
      end else if (any) begin
        state_d = SUSPECT;
        grace_cnt_d = 4'd1;
        pend_d = f;
      end
    end else if (state_q == SUSPECT) begin
      if (!any) begin
        state_d = IDLE;
        grace_cnt_d = 4'd0;
        pend_d = 4'd0;
      end else if (f[3] || grace_cnt_q + 4'd1 == GRACE) begin
        state_d = ALARM;
        cause_d = pend_q | f;
        grace_cnt_d = 4'd0;
        pend_d = 4'd0;
      end else begin
        grace_cnt_d = grace_cnt_q + 4'd1;
        pend_d = pend_q | f;
      end
    end else begin
      cause_d = cause_q | f;
      state_d = (state_q == ALARM && recover_ack) ? RECOVER : state_q;
    end
    viol_count_d = viol_count_q + {7'd0, state_d == ALARM && state_q != ALARM && viol_count_q != 8'hff};
    alarm_d = state_d == ALARM || state_d == RECOVER;
    recover_req_d = state_d == ALARM;
    supv_dec_d = supv_now;
    exc_prev_d = except_started;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grace_cnt_q <= 4'd0;
      pend_q <= 4'd0;
      cause_q <= 4'd0;
      viol_count_q <= 8'd0;
      supv_dec_q <= 1'b1;
      exc_prev_q <= 1'b0;
      alarm_q <= 1'b0;
      recover_req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grace_cnt_q <= grace_cnt_d;
      pend_q <= pend_d;
      cause_q <= cause_d;
      viol_count_q <= viol_count_d;
      supv_dec_q <= supv_dec_d;
      exc_prev_q <= exc_prev_d;
      alarm_q <= alarm_d;
      recover_req_q <= recover_req_d;
    end
  end
  assign alarm = alarm_q;
  assign recover_req = recover_req_q;
  assign cause = cause_q;
  assign supv_dec = supv_dec_q;
  assign viol_count = viol_count_q;
  assign state = state_q;
endmodule

// File: tb/tb_or1200_checker_alarm.sv
// tb_or1200_checker_alarm: directed stimulus checked against a streak-based reference model
module tb_or1200_checker_alarm;
  localparam int G = 2;
  logic clk = 0, rst = 1, enable = 1, sr_ok = 1, pipeline_ok = 1, mmus_ok = 1;
  logic [2:0] secure_supv = 3'b000;
  logic except_started = 0, recover_ack = 0, clear = 0;
  logic alarm, recover_req, supv_dec;
  logic [3:0] cause;
  logic [7:0] viol_count;
  logic [1:0] state;
  int n_vec = 0, n_err = 0;
  bit chk_on = 0;
  int m_state = 0, m_streak = 0, m_viol = 0;
  logic [3:0] m_acc = 0, m_cause = 0;
  bit m_supv = 1, m_exc = 0;

  or1200_checker_alarm #(.GRACE_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sr_ok(sr_ok), .pipeline_ok(pipeline_ok),
    .mmus_ok(mmus_ok), .secure_supv(secure_supv), .except_started(except_started),
    .recover_ack(recover_ack), .clear(clear), .alarm(alarm), .recover_req(recover_req),
    .cause(cause), .supv_dec(supv_dec), .viol_count(viol_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: count consecutive faulting cycles; alarm when the streak reaches G or on escalation
  always @(posedge clk) begin
    bit sv, esc;
    logic [3:0] f;
    if (rst) begin
      m_state = 0; m_streak = 0; m_acc = 0; m_cause = 0; m_viol = 0; m_supv = 1; m_exc = 0;
    end else begin
      sv = ~^secure_supv;
      esc = enable && sv && !m_supv && !except_started && !m_exc;
      f = enable ? {esc, !mmus_ok, !pipeline_ok, !sr_ok} : 4'b0;
      if (m_state == 2 || (m_state == 3 && !clear)) begin
        m_cause |= f;
        if (m_state == 2 && recover_ack) m_state = 3;
      end else begin
        if (m_state == 3) begin m_cause = 0; m_streak = 0; m_acc = 0; end
        if (f == 0) begin
          m_state = 0; m_streak = 0; m_acc = 0;
        end else begin
          m_streak++;
          m_acc |= f;
          if (f[3] || m_streak >= G) begin
            m_cause = m_acc; m_state = 2; m_streak = 0; m_acc = 0;
            if (m_viol < 255) m_viol++;
          end else m_state = 1;
        end
      end
      m_supv = sv;
      m_exc = except_started;
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("state", {6'd0, state}, 8'(m_state));
    chk("alarm", {7'd0, alarm}, {7'd0, m_state >= 2});
    chk("recover_req", {7'd0, recover_req}, {7'd0, m_state == 2});
    chk("cause", {4'd0, cause}, {4'd0, m_cause});
    chk("supv_dec", {7'd0, supv_dec}, {7'd0, m_supv});
    chk("viol_count", viol_count, 8'(m_viol));
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic escalate_and_close();
    secure_supv = 3'b001; tick();
    secure_supv = 3'b011; tick();
    recover_ack = 1; tick();
    recover_ack = 0; clear = 1; tick();
    clear = 0;
  endtask

  initial begin
    tick(2);
    chk_on = 1;
    chk("rst_state", {6'd0, state}, 8'd0);
    chk("rst_alarm", {7'd0, alarm}, 8'd0);
    chk("rst_cause", {4'd0, cause}, 8'd0);
    chk("rst_viol", viol_count, 8'd0);
    chk("rst_supv", {7'd0, supv_dec}, 8'd1);
    rst = 0; tick();
    sr_ok = 0; tick();
    chk("glitch_suspect", {6'd0, state}, 8'd1);
    sr_ok = 1; tick();
    chk("glitch_idle", {6'd0, state}, 8'd0);
    chk("glitch_alarm", {7'd0, alarm}, 8'd0);
    pipeline_ok = 0; tick();
    mmus_ok = 0; tick();
    pipeline_ok = 1; mmus_ok = 1;
    chk("pipe_alarm", {7'd0, alarm}, 8'd1);
    chk("pipe_req", {7'd0, recover_req}, 8'd1);
    chk("pipe_cause", {4'd0, cause}, 8'h06);
    chk("pipe_viol", viol_count, 8'd1);
    recover_ack = 1; tick();
    recover_ack = 0;
    chk("ack_req", {7'd0, recover_req}, 8'd0);
    chk("ack_alarm", {7'd0, alarm}, 8'd1);
    clear = 1; tick();
    clear = 0;
    chk("clr_alarm", {7'd0, alarm}, 8'd0);
    chk("clr_state", {6'd0, state}, 8'd0);
    chk("clr_cause", {4'd0, cause}, 8'd0);
    recover_ack = 1; tick();
    recover_ack = 0;
    chk("idle_ack", {6'd0, state}, 8'd0);
    secure_supv = 3'b001; tick();
    chk("user_dec", {7'd0, supv_dec}, 8'd0);
    secure_supv = 3'b011; tick();
    chk("esc_alarm", {7'd0, alarm}, 8'd1);
    chk("esc_cause", {4'd0, cause}, 8'h08);
    recover_ack = 1; tick();
    recover_ack = 0; clear = 1; tick();
    clear = 0;
    secure_supv = 3'b001; tick();
    except_started = 1; tick();
    except_started = 0; secure_supv = 3'b011; tick();
    tick();
    chk("exc_no_alarm", {7'd0, alarm}, 8'd0);
    enable = 0; sr_ok = 0; pipeline_ok = 0; mmus_ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("masked_state", {6'd0, state}, 8'd0);
    end
    enable = 1; tick();
    chk("unmask_suspect", {6'd0, state}, 8'd1);
    sr_ok = 1; pipeline_ok = 1; mmus_ok = 1; tick();
    for (int i = 0; i < 256; i++) escalate_and_close();
    chk("viol_sat", viol_count, 8'd255);
    secure_supv = 3'b001; tick();
    secure_supv = 3'b011; tick();
    chk("pre_rst_alarm", {7'd0, alarm}, 8'd1);
    rst = 1; tick();
    chk("mid_rst_state", {6'd0, state}, 8'd0);
    chk("mid_rst_alarm", {7'd0, alarm}, 8'd0);
    chk("mid_rst_req", {7'd0, recover_req}, 8'd0);
    chk("mid_rst_cause", {4'd0, cause}, 8'd0);
    chk("mid_rst_viol", viol_count, 8'd0);
    chk("mid_rst_supv", {7'd0, supv_dec}, 8'd1);
    rst = 0; tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
